pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage MIPS pipeline; sits beside the ID stage.

---
 rtl/mips_pipe_pkg.sv | 11 +
 rtl/pipeline_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline hazard/stall control slice.
package mips_pipe_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler beside ID: merges load-use, redirects and mult/div hazards
// into PC / IF-ID / ID-EX controls, owns the mult/div issue handshake and statistics.
module pipeline_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_dst,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             id_md_op,
    input  logic             id_mfhilo,
    input  logic             md_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned TO_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    md_state_e       state;
    md_state_e       state_next;
    logic [TO_W-1:0] to_cnt;
    logic            to_expire;
    logic            load_use;
    logic            md_hold;
    logic            stall;

    assign md_busy  = (state == ST_MD_BUSY);
    assign load_use = id_ex_memread
                    && (id_ex_dst != REG_W'(REG_ZERO))
                    && ((id_ex_dst == if_id_rs) || (id_ex_dst == if_id_rt));
    assign md_hold  = md_busy && (id_md_op || id_mfhilo);
    assign stall    = load_use || md_hold;

    // State, timeout counter and sticky error; counter restarts on every MD_BUSY entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            to_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            state  <= state_next;
            to_cnt <= (state == ST_MD_BUSY) ? to_cnt + TO_W'(1) : '0;
            if (to_expire) begin
                md_timeout <= 1'b1;
            end
        end
    end

    // Next state and same-cycle pipeline controls; stall outranks redirect.
    always_comb begin
        state_next   = state;
        to_expire    = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        md_start     = 1'b0;

        if (rst_n) begin
            if (stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (id_branch_taken || id_jump) begin
                if_id_flush = 1'b1;
            end

            unique case (state)
                ST_RUN: begin
                    if (!stall && id_md_op) begin
                        md_start   = 1'b1;
                        state_next = ST_MD_BUSY;
                    end
                end
                ST_MD_BUSY: begin
                    if (md_done) begin
                        state_next = ST_RUN;
                    end else if (to_cnt == TO_LAST) begin
                        to_expire  = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .en    (!pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .en    (if_id_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: default instance plus a short-timeout instance.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_ex_memread;
    logic [4:0]  id_ex_dst;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        id_branch_taken;
    logic        id_jump;
    logic        id_md_op;
    logic        id_mfhilo;
    logic        md_done;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic        md_start, md_busy, md_timeout;
    logic [15:0] stall_cycles, flush_count;

    logic        pc_write_to, if_id_write_to, if_id_flush_to, id_ex_bubble_to;
    logic        md_start_to, md_busy_to, md_timeout_to;
    logic [15:0] stall_cycles_to, flush_count_to;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_memread(id_ex_memread), .id_ex_dst(id_ex_dst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .id_md_op(id_md_op), .id_mfhilo(id_mfhilo), .md_done(md_done),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .md_start(md_start), .md_busy(md_busy),
        .md_timeout(md_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_stall_ctrl #(.MD_TIMEOUT(8)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .id_ex_memread(id_ex_memread), .id_ex_dst(id_ex_dst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .id_md_op(id_md_op), .id_mfhilo(id_mfhilo), .md_done(md_done),
        .pc_write(pc_write_to), .if_id_write(if_id_write_to), .if_id_flush(if_id_flush_to),
        .id_ex_bubble(id_ex_bubble_to), .md_start(md_start_to), .md_busy(md_busy_to),
        .md_timeout(md_timeout_to), .stall_cycles(stall_cycles_to),
        .flush_count(flush_count_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_ex_memread   = 1'b0;
        id_ex_dst       = 5'd0;
        if_id_rs        = 5'd1;
        if_id_rt        = 5'd2;
        id_branch_taken = 1'b0;
        id_jump         = 1'b0;
        id_md_op        = 1'b0;
        id_mfhilo       = 1'b0;
        md_done         = 1'b0;
    endtask

    // Advance one edge; inputs are then driven 1ns after it, comb outputs read 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load_use_vec(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
        id_ex_memread = 1'b1;
        id_ex_dst     = dst;
        if_id_rs      = rs;
        if_id_rt      = rt;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        // Hazard present during reset: outputs must still be forced to run values.
        load_use_vec(5'd8, 5'd8, 5'd9);
        tick(); tick();
        settle();
        check("rst_pc_write", 32'(pc_write), 32'd1);
        check("rst_bubble", 32'(id_ex_bubble), 32'd0);
        check("rst_md_busy", 32'(md_busy), 32'd0);
        check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        check("rst_md_timeout", 32'(md_timeout), 32'd0);

        rst_n = 1'b1;
        idle();
        tick();

        // lw $t0 in EX, rs=8 in ID
        load_use_vec(5'd8, 5'd8, 5'd9);
        settle();
        check("lu_rs_pc_write", 32'(pc_write), 32'd0);
        check("lu_rs_if_id_write", 32'(if_id_write), 32'd0);
        check("lu_rs_bubble", 32'(id_ex_bubble), 32'd1);
        tick();
        idle();
        settle();
        check("lu_rs_stall_cycles", 32'(stall_cycles), 32'd1);
        check("lu_after_pc_write", 32'(pc_write), 32'd1);

        // match on rt
        load_use_vec(5'd9, 5'd3, 5'd9);
        settle();
        check("lu_rt_bubble", 32'(id_ex_bubble), 32'd1);
        tick();
        idle();

        // $zero destination never hazards; no memread never hazards
        load_use_vec(5'd0, 5'd0, 5'd0);
        settle();
        check("lu_zero_pc_write", 32'(pc_write), 32'd1);
        check("lu_zero_bubble", 32'(id_ex_bubble), 32'd0);
        id_ex_memread = 1'b0;
        id_ex_dst     = 5'd8;
        if_id_rs      = 5'd8;
        settle();
        check("no_load_if_id_write", 32'(if_id_write), 32'd1);
        tick();
        idle();

        // load-use together with a taken branch: stall wins, flush next cycle
        load_use_vec(5'd8, 5'd8, 5'd9);
        id_branch_taken = 1'b1;
        settle();
        check("lu_br_pc_write", 32'(pc_write), 32'd0);
        check("lu_br_flush", 32'(if_id_flush), 32'd0);
        tick();
        id_ex_memread = 1'b0;
        settle();
        check("br_flush", 32'(if_id_flush), 32'd1);
        check("br_pc_write", 32'(pc_write), 32'd1);
        check("br_if_id_write", 32'(if_id_write), 32'd1);
        tick();
        idle();
        settle();
        check("br_flush_count", 32'(flush_count), 32'd1);
        check("br_stall_cycles", 32'(stall_cycles), 32'd3);

        id_jump = 1'b1;
        settle();
        check("jump_flush", 32'(if_id_flush), 32'd1);
        tick();
        idle();

        // mult issues at cycle 0
        id_md_op = 1'b1;
        settle();
        check("mult_md_start", 32'(md_start), 32'd1);
        check("mult_bubble", 32'(id_ex_bubble), 32'd0);
        check("mult_pc_write", 32'(pc_write), 32'd1);
        tick();
        // cycle 1: unrelated add plus taken branch proceed while busy
        idle();
        id_branch_taken = 1'b1;
        settle();
        check("busy_md_busy", 32'(md_busy), 32'd1);
        check("busy_md_start", 32'(md_start), 32'd0);
        check("busy_add_pc_write", 32'(pc_write), 32'd1);
        check("busy_br_flush", 32'(if_id_flush), 32'd1);
        tick();
        // cycle 2: second mult in ID held, no issue
        idle();
        id_md_op = 1'b1;
        settle();
        check("busy_mult_pc_write", 32'(pc_write), 32'd0);
        check("busy_mult_md_start", 32'(md_start), 32'd0);
        tick();
        // cycles 3..9: mflo held
        idle();
        id_mfhilo = 1'b1;
        for (int c = 3; c <= 9; c++) begin
            settle();
            if (c == 9) check("mflo_held_c9", 32'(id_ex_bubble), 32'd1);
            tick();
        end
        // cycle 10: md_done, mflo still held
        md_done = 1'b1;
        settle();
        check("mflo_done_cycle_pc_write", 32'(pc_write), 32'd0);
        tick();
        // cycle 11: mflo proceeds
        md_done = 1'b0;
        settle();
        check("mflo_release_md_busy", 32'(md_busy), 32'd0);
        check("mflo_release_pc_write", 32'(pc_write), 32'd1);
        check("mflo_release_bubble", 32'(id_ex_bubble), 32'd0);
        tick();
        idle();
        settle();
        check("mult_stall_cycles", 32'(stall_cycles), 32'd12);
        check("mult_flush_count", 32'(flush_count), 32'd3);
        // stray md_done in RUN is ignored
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        settle();
        check("done_in_run_md_busy", 32'(md_busy), 32'd0);

        // timeout scenario on the MD_TIMEOUT=8 instance
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        settle();
        check("to_rst_md_timeout", 32'(md_timeout_to), 32'd0);
        check("to_rst_flush_count", 32'(flush_count_to), 32'd0);
        id_md_op = 1'b1;
        settle();
        check("to_md_start", 32'(md_start_to), 32'd1);
        tick();
        idle();
        id_mfhilo = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            settle();
            if (c == 8) begin
                check("to_c8_md_busy", 32'(md_busy_to), 32'd1);
                check("to_c8_md_timeout", 32'(md_timeout_to), 32'd0);
                check("to_c8_pc_write", 32'(pc_write_to), 32'd0);
            end
            tick();
        end
        settle();
        check("to_md_timeout", 32'(md_timeout_to), 32'd1);
        check("to_md_busy", 32'(md_busy_to), 32'd0);
        check("to_release_if_id_write", 32'(if_id_write_to), 32'd1);
        check("to_release_bubble", 32'(id_ex_bubble_to), 32'd0);
        check("to_flush", 32'(if_id_flush_to), 32'd0);
        check("to_stall_cycles", 32'(stall_cycles_to), 32'd8);
        check("long_still_busy", 32'(md_busy), 32'd1);
        check("long_still_held", 32'(pc_write), 32'd0);

        // reset while MD_BUSY aborts the operation and clears statistics
        rst_n = 1'b0;
        tick();
        settle();
        check("abort_md_busy", 32'(md_busy), 32'd0);
        check("abort_stall_cycles", 32'(stall_cycles), 32'd0);
        check("abort_flush_count", 32'(flush_count), 32'd0);
        check("abort_md_timeout_to", 32'(md_timeout_to), 32'd0);
        rst_n = 1'b1;
        idle();

        // continuous stall until saturation
        load_use_vec(5'd8, 5'd8, 5'd9);
        repeat (65535) tick();
        settle();
        check("sat_reach", 32'(stall_cycles), 32'h0000_FFFF);
        tick();
        settle();
        check("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);
        check("sat_pc_write", 32'(pc_write), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
